// File: rtl/lc4_seq_divider_pkg.sv
// Shared definitions for the LC4 sequential divider: control states and
// word/iteration sizing used by the top level and the adder.
package lc4_seq_divider_pkg;

  localparam int LC4_WORD   = 16;
  localparam int ITER_COUNT = 16;
  // Wide enough to hold ITER_COUNT itself; the counter parks at 16.
  localparam int CNT_W      = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/lc4_seq_divider_cla16.sv
// 16-bit two-level carry-lookahead adder (four 4-bit groups).
// The divider uses it for the trial subtraction a + ~b + 1.
module lc4_seq_divider_cla16
  import lc4_seq_divider_pkg::*;
(
  input  logic [LC4_WORD-1:0] a,
  input  logic [LC4_WORD-1:0] b,
  input  logic                cin,
  output logic [LC4_WORD-1:0] sum
);

  // Bit 15 generate is only needed for a carry-out, which nobody uses.
  logic [LC4_WORD-2:0] g;
  logic [LC4_WORD-1:0] p;
  logic [LC4_WORD-1:0] c;
  logic [2:0]          gg;
  logic [2:0]          gp;
  logic [3:0]          cg;

  assign g = a[LC4_WORD-2:0] & b[LC4_WORD-2:0];
  assign p = a ^ b;

  // Group generate/propagate for the three lower groups (group 3 feeds no carry).
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_grp_gp
      localparam int B = 4 * gi;
      assign gg[gi] = g[B+3]
                    | (p[B+3] & g[B+2])
                    | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp[gi] = &p[B+3:B];
    end
  endgenerate

  // Second-level lookahead: carry into each group straight from cin.
  assign cg[0] = cin;
  assign cg[1] = gg[0] | (gp[0] & cin);
  assign cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);

  // First-level lookahead: bit carries inside each group from its group carry-in.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp_bits
      localparam int B = 4 * gi;
      assign c[B]   = cg[gi];
      assign c[B+1] = g[B] | (p[B] & cg[gi]);
      assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[gi]);
      assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                    | (p[B+2] & p[B+1] & p[B] & cg[gi]);
    end
  endgenerate

  assign sum = p ^ c;

endmodule

// File: rtl/lc4_seq_divider.sv
// LC4 DIV/MOD unit: unsigned 16-bit restoring radix-2 divider, one quotient
// bit per cycle, with valid/ready handshakes on operands and result.
module lc4_seq_divider
  import lc4_seq_divider_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit DIV0_FAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  // The datapath is tied to the 16-bit adder; refuse to build any other width.
  generate
    if (WIDTH != LC4_WORD) begin : g_width_check
      $error("lc4_seq_divider: WIDTH must be 16");
    end
  endgenerate

  state_t           state_reg;
  logic [WIDTH-1:0] q_reg;          // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] d_reg;          // divisor
  logic [WIDTH-1:0] r_reg;          // partial remainder
  logic [CNT_W-1:0] cnt_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] d_inv;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             t;
  logic             ge;
  logic             last_iter;

  assign d_inv     = ~d_reg;
  assign last_iter = (cnt_reg == CNT_W'(ITER_COUNT - 1));

  // Trial subtraction S - D as S + ~D + 1.
  lc4_seq_divider_cla16 u_cla (
    .a   (s),
    .b   (d_inv),
    .cin (1'b1),
    .sum (diff)
  );

  // One restoring step: shift in the next dividend bit, keep the difference
  // when it fits. T (the bit shifted out of R) means S+2^16 >= D for sure.
  always_comb begin
    s      = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    t      = r_reg[WIDTH-1];
    ge     = t | (s >= d_reg);
    r_next = ge ? diff : s;
    q_next = {q_reg[WIDTH-2:0], ge};
  end

  // Control FSM plus all datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      d_reg         <= '0;
      r_reg         <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            q_reg   <= dividend_i;
            d_reg   <= divisor_i;
            r_reg   <= '0;
            cnt_reg <= '0;
            if (DIV0_FAST && (divisor_i == '0)) begin
              // Zero divisor short-circuits straight to a 0/0 result.
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              quotient_reg  <= '0;
              remainder_reg <= '0;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          r_reg   <= r_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last_iter) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            // LC4 defines x/0 and x%0 as 0; the iterations ran only for timing.
            if (d_reg == '0) begin
              quotient_reg  <= '0;
              remainder_reg <= '0;
            end else begin
              quotient_reg  <= q_next;
              remainder_reg <= r_next;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = out_valid_reg;
  assign quotient_o  = quotient_reg;
  assign remainder_o = remainder_reg;

endmodule

// File: tb/tb_lc4_seq_divider.sv
// Bench for lc4_seq_divider: one instance with DIV0_FAST=1, one with 0.
// A handshake-level model per instance is checked every cycle; directed
// transactions additionally pin literal quotients, remainders and latencies.
`timescale 1ns/1ps
module tb_lc4_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv   [2];
  logic        iry  [2];
  logic [15:0] dvd  [2];
  logic [15:0] dvs  [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [15:0] qo   [2];
  logic [15:0] ro   [2];

  int checks = 0;
  int errors = 0;

  localparam bit [1:0] FAST = 2'b01;  // instance 0 fast, instance 1 slow

  always #5 clk = ~clk;

  lc4_seq_divider #(.WIDTH(16), .DIV0_FAST(1'b1)) dut_fast (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(iry[0]),
    .dividend_i(dvd[0]), .divisor_i(dvs[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .quotient_o(qo[0]), .remainder_o(ro[0])
  );

  lc4_seq_divider #(.WIDTH(16), .DIV0_FAST(1'b0)) dut_slow (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(iry[1]),
    .dividend_i(dvd[1]), .divisor_i(dvs[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .quotient_o(qo[1]), .remainder_o(ro[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0 = accepting, 1 = computing, 2 = result offered
  logic [1:0]  m_phase [2];
  int          m_left  [2];
  logic [15:0] m_nq    [2];
  logic [15:0] m_nr    [2];
  logic [15:0] m_q     [2];
  logic [15:0] m_r     [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_phase[k] <= 2'd0;
        m_left[k]  <= 0;
        m_nq[k]    <= 16'd0;
        m_nr[k]    <= 16'd0;
        m_q[k]     <= 16'd0;
        m_r[k]     <= 16'd0;
      end else begin
        case (m_phase[k])
          2'd0: if (iv[k]) begin
            m_nq[k] <= (dvs[k] == 16'd0) ? 16'd0 : dvd[k] / dvs[k];
            m_nr[k] <= (dvs[k] == 16'd0) ? 16'd0 : dvd[k] % dvs[k];
            if (dvs[k] == 16'd0 && FAST[k]) begin
              m_phase[k] <= 2'd2;
              m_q[k]     <= 16'd0;
              m_r[k]     <= 16'd0;
            end else begin
              m_phase[k] <= 2'd1;
              m_left[k]  <= 16;
            end
          end
          2'd1: begin
            m_left[k] <= m_left[k] - 1;
            if (m_left[k] == 1) begin
              m_phase[k] <= 2'd2;
              m_q[k]     <= m_nq[k];
              m_r[k]     <= m_nr[k];
            end
          end
          default: if (ordy[k]) m_phase[k] <= 2'd0;
        endcase
      end
    end
  end

  // Compare DUT against model on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check($sformatf("rst%0d out_valid", k), ov[k], 0);
        check($sformatf("rst%0d quotient", k), qo[k], 0);
        check($sformatf("rst%0d remainder", k), ro[k], 0);
      end else begin
        check($sformatf("mdl%0d in_ready", k), iry[k], m_phase[k] == 2'd0);
        check($sformatf("mdl%0d out_valid", k), ov[k], m_phase[k] == 2'd2);
        if (m_phase[k] != 2'd1) begin
          check($sformatf("mdl%0d quotient", k), qo[k], m_q[k]);
          check($sformatf("mdl%0d remainder", k), ro[k], m_r[k]);
        end
      end
    end
  end

  // ---------------- directed transaction ----------------
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input int elat, input int stall, input bit hold, input string nm);
    int lat;
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (iry[k]) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check({nm, " ready_wait"}, seen, 1);
    iv[k]  = 1'b1;
    dvd[k] = a;
    dvs[k] = b;
    @(posedge clk); #1;
    if (hold) begin
      dvd[k] = ~a;
      dvs[k] = 16'h0001;
    end else begin
      iv[k] = 1'b0;
    end
    lat  = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ov[k]) begin seen = 1; break; end
      check({nm, " in_ready_busy"}, iry[k], 0);
      @(posedge clk); #1;
      lat++;
    end
    iv[k] = 1'b0;
    check({nm, " out_valid_seen"}, seen, 1);
    check({nm, " latency"}, lat, elat);
    check({nm, " quotient"}, qo[k], eq);
    check({nm, " remainder"}, ro[k], er);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({nm, " stall_valid"}, ov[k], 1);
      check({nm, " stall_quotient"}, qo[k], eq);
      check({nm, " stall_remainder"}, ro[k], er);
      check({nm, " stall_in_ready"}, iry[k], 0);
    end
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    check({nm, " released_valid"}, ov[k], 0);
    check({nm, " released_in_ready"}, iry[k], 1);
    $display("op %s inst=%0d %0d/%0d -> q=%0d r=%0d lat=%0d", nm, k, a, b, qo[k], ro[k], lat);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b, eq, er;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; dvd[k] = 16'd0; dvs[k] = 16'd0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset in_ready", iry[0], 1);
    check("reset out_valid", ov[0], 0);
    check("reset quotient", qo[0], 0);
    check("reset remainder", ro[0], 0);

    run_op(0, 16'd100,  16'd7,      16'd14,     16'd2,      16, 0, 0, "100div7");
    run_op(0, 16'hFFFF, 16'h0001,   16'hFFFF,   16'h0000,   16, 1, 0, "ffff_div1");
    run_op(0, 16'h8000, 16'hFFFF,   16'h0000,   16'h8000,   16, 0, 0, "8000_divffff");
    run_op(0, 16'hFFFF, 16'h8000,   16'h0001,   16'h7FFF,   16, 2, 0, "ffff_div8000");
    run_op(0, 16'd5,    16'd0,      16'd0,      16'd0,      0,  1, 0, "div0_fast");
    run_op(1, 16'd5,    16'd0,      16'd0,      16'd0,      16, 1, 0, "div0_slow");
    run_op(1, 16'd100,  16'd7,      16'd14,     16'd2,      16, 0, 0, "slow_100div7");
    run_op(0, 16'h1234, 16'h0010,   16'h0123,   16'h0004,   16, 5, 1, "backpressure");

    // Reset in the middle of a computation.
    iv[0] = 1'b1; dvd[0] = 16'h1234; dvs[0] = 16'd3;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst out_valid", ov[0], 0);
    check("midrst quotient", qo[0], 0);
    check("midrst remainder", ro[0], 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("midrst in_ready", iry[0], 1);
    $display("op midreset inst=0 aborted, in_ready=%0d", iry[0]);
    repeat (20) @(posedge clk);
    #1;
    run_op(0, 16'd1000, 16'd10, 16'd100, 16'd0, 16, 0, 0, "1000div10");

    // Random pairs with zero divisors and output stalls.
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 16'd0;
        1, 2, 3: b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom);
      endcase
      eq = (b == 16'd0) ? 16'd0 : a / b;
      er = (b == 16'd0) ? 16'd0 : a % b;
      run_op(0, a, b, eq, er, (b == 16'd0) ? 0 : 16, $urandom_range(0, 3),
             $urandom_range(0, 3) == 0, $sformatf("rnd%0d", i));
    end
    for (int i = 0; i < 30; i++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
      eq = (b == 16'd0) ? 16'd0 : a / b;
      er = (b == 16'd0) ? 16'd0 : a % b;
      run_op(1, a, b, eq, er, 16, $urandom_range(0, 2), 0, $sformatf("slowrnd%0d", i));
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
